// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - state encoding and counter sizing for the PLL reset sequencer
package pll_seq_pkg;

   typedef enum logic [1:0] {
      ST_PLL_RST   = 2'd0,
      ST_WAIT_LOCK = 2'd1,
      ST_RELEASE   = 2'd2,
      ST_RUN       = 2'd3
   } pll_seq_state_e;

   // Bits needed to hold 0..max_val; never narrower than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// rtl/pll_lock_sync.sv - two-flop synchronizer for the asynchronous PLL lock
// Ports: clk (sampling clock), rst_n (async active-low), d (async input), q (synchronized output)
module pll_lock_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/pll_reset_seq.sv
// rtl/pll_reset_seq.sv - PLL reset, lock qualification and staggered domain reset release
// Ports: clk (free-running oscillator), reset (async active-low), pll_lock (async),
//        sw_reset_req (restart request), pll_resetb (PLL RESETB pin), rst_out_n (per-domain
//        active-low resets), ready (all domains out of reset), unlock_count (saturating
//        loss-of-lock events), lock_fail (sticky lock timeout), state (debug FSM state).
// Build option: PLL_SEQ_TIMEOUT_EN adds a WAIT_LOCK timeout and the sticky lock_fail flag.
module pll_reset_seq
   import pll_seq_pkg::*;
#(
   parameter int NUM_DOMAINS        = 2,
   parameter int PLL_RST_CYCLES     = 16,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int STAGGER_CYCLES     = 64,
   parameter int LOSS_FILTER        = 4,
   parameter int LOCK_TIMEOUT       = 65535
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   pll_lock,
   input  logic                   sw_reset_req,
   output logic                   pll_resetb,
   output logic [NUM_DOMAINS-1:0] rst_out_n,
   output logic                   ready,
   output logic [7:0]             unlock_count,
   output logic                   lock_fail,
   output logic [1:0]             state
);

   localparam int RST_W  = cnt_width(PLL_RST_CYCLES - 1);
   localparam int STB_W  = cnt_width(LOCK_STABLE_CYCLES - 1);
   localparam int STG_W  = cnt_width(STAGGER_CYCLES - 1);
   localparam int LOSS_W = cnt_width(LOSS_FILTER - 1);

   logic lock_s;

   pll_lock_sync u_lock_sync (
      .clk   (clk),
      .rst_n (reset),
      .d     (pll_lock),
      .q     (lock_s)
   );

   pll_seq_state_e         state_q, state_d;
   logic [RST_W-1:0]       rst_cnt_q, rst_cnt_d;
   logic [STB_W-1:0]       stable_cnt_q, stable_cnt_d;
   logic [STG_W-1:0]       stg_cnt_q, stg_cnt_d;
   logic [LOSS_W-1:0]      loss_cnt_q, loss_cnt_d;
   logic                   pll_resetb_q, pll_resetb_d;
   logic [NUM_DOMAINS-1:0] rst_out_n_q, rst_out_n_d;
   logic                   ready_q, ready_d;
   logic [7:0]             unlock_cnt_q, unlock_cnt_d;
   logic                   loss_det;
`ifdef PLL_SEQ_TIMEOUT_EN
   localparam int TO_W = cnt_width(LOCK_TIMEOUT - 1);
   logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
   logic                   lock_fail_q, lock_fail_d;
`endif

   always_comb begin
      state_d      = state_q;
      rst_cnt_d    = '0;
      stable_cnt_d = '0;
      stg_cnt_d    = '0;
      loss_cnt_d   = '0;
      pll_resetb_d = pll_resetb_q;
      rst_out_n_d  = rst_out_n_q;
      ready_d      = ready_q;
      unlock_cnt_d = unlock_cnt_q;
      loss_det     = 1'b0;
`ifdef PLL_SEQ_TIMEOUT_EN
      to_cnt_d     = '0;
      lock_fail_d  = lock_fail_q;
`endif

      // Loss filter only runs once domains start leaving reset; any high sample clears it.
      if ((state_q == ST_RELEASE || state_q == ST_RUN) && !lock_s) begin
         if (loss_cnt_q == LOSS_W'(LOSS_FILTER - 1)) begin
            loss_det = 1'b1;
         end else begin
            loss_cnt_d = loss_cnt_q + LOSS_W'(1);
         end
      end

      case (state_q)
         ST_PLL_RST: begin
            pll_resetb_d = 1'b0;
            rst_out_n_d  = '0;
            ready_d      = 1'b0;
            if (rst_cnt_q == RST_W'(PLL_RST_CYCLES - 1)) begin
               state_d      = ST_WAIT_LOCK;
               pll_resetb_d = 1'b1;
            end else begin
               rst_cnt_d = rst_cnt_q + RST_W'(1);
            end
         end
         ST_WAIT_LOCK: begin
            if (lock_s && stable_cnt_q == STB_W'(LOCK_STABLE_CYCLES - 1)) begin
               // Domain 0 leaves reset on the very first RELEASE cycle.
               state_d     = ST_RELEASE;
               rst_out_n_d = NUM_DOMAINS'(1);
            end else begin
               if (lock_s) begin
                  stable_cnt_d = stable_cnt_q + STB_W'(1);
               end
`ifdef PLL_SEQ_TIMEOUT_EN
               if (to_cnt_q == TO_W'(LOCK_TIMEOUT - 1)) begin
                  state_d      = ST_PLL_RST;
                  pll_resetb_d = 1'b0;
                  lock_fail_d  = 1'b1;
                  stable_cnt_d = '0;
               end else begin
                  to_cnt_d = to_cnt_q + TO_W'(1);
               end
`endif
            end
         end
         ST_RELEASE: begin
            if (rst_out_n_q[NUM_DOMAINS-1]) begin
               state_d = ST_RUN;
               ready_d = 1'b1;
            end else if (stg_cnt_q == STG_W'(STAGGER_CYCLES - 1)) begin
               // Released domains form a contiguous run of ones from bit 0; extend it by one.
               for (int i = NUM_DOMAINS - 1; i > 0; i--) begin
                  rst_out_n_d[i] = rst_out_n_q[i-1];
               end
               rst_out_n_d[0] = 1'b1;
            end else begin
               stg_cnt_d = stg_cnt_q + STG_W'(1);
            end
         end
         default: begin
         end
      endcase

      // Restart overrides everything; only a genuine loss of lock is counted.
      if (sw_reset_req || loss_det) begin
         state_d      = ST_PLL_RST;
         rst_cnt_d    = '0;
         stable_cnt_d = '0;
         stg_cnt_d    = '0;
         loss_cnt_d   = '0;
         pll_resetb_d = 1'b0;
         rst_out_n_d  = '0;
         ready_d      = 1'b0;
`ifdef PLL_SEQ_TIMEOUT_EN
         to_cnt_d     = '0;
`endif
         if (loss_det && unlock_cnt_q != 8'hFF) begin
            unlock_cnt_d = unlock_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_PLL_RST;
         rst_cnt_q    <= '0;
         stable_cnt_q <= '0;
         stg_cnt_q    <= '0;
         loss_cnt_q   <= '0;
         pll_resetb_q <= 1'b0;
         rst_out_n_q  <= '0;
         ready_q      <= 1'b0;
         unlock_cnt_q <= '0;
`ifdef PLL_SEQ_TIMEOUT_EN
         to_cnt_q     <= '0;
         lock_fail_q  <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         rst_cnt_q    <= rst_cnt_d;
         stable_cnt_q <= stable_cnt_d;
         stg_cnt_q    <= stg_cnt_d;
         loss_cnt_q   <= loss_cnt_d;
         pll_resetb_q <= pll_resetb_d;
         rst_out_n_q  <= rst_out_n_d;
         ready_q      <= ready_d;
         unlock_cnt_q <= unlock_cnt_d;
`ifdef PLL_SEQ_TIMEOUT_EN
         to_cnt_q     <= to_cnt_d;
         lock_fail_q  <= lock_fail_d;
`endif
      end
   end

   assign pll_resetb   = pll_resetb_q;
   assign rst_out_n    = rst_out_n_q;
   assign ready        = ready_q;
   assign unlock_count = unlock_cnt_q;
   assign state        = state_q;
`ifdef PLL_SEQ_TIMEOUT_EN
   assign lock_fail    = lock_fail_q;
`else
   assign lock_fail    = 1'b0;
`endif

endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 SHALL have parameter NUM_DOMAINS, default 2: number of reset domains sequenced, range 1-8.
REQ-002 SHALL have parameter PLL_RST_CYCLES, default 16: cycles pll_resetb is held low per PLL reset attempt, at least 1.
REQ-003 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before release.
REQ-004 SHALL have parameter STAGGER_CYCLES, default 64: cycles between successive domain releases, at least 1.
REQ-005 SHALL have parameter LOSS_FILTER, default 4: consecutive synchronized-unlock cycles that count as loss of lock.
REQ-006 SHALL have parameter LOCK_TIMEOUT, default 65535: WAIT_LOCK cycle budget, used only under PLL_SEQ_TIMEOUT_EN.
REQ-007 SHALL have port clk, input, 1 bit: free-running oscillator clock, not PLL-derived.
REQ-008 SHALL have port reset, input, 1 bit: asynchronous, active-low.
REQ-009 SHALL have port pll_lock, input, 1 bit: asynchronous PLL LOCK.
REQ-010 SHALL have port sw_reset_req, input, 1 bit: synchronous request to restart the sequence.
REQ-011 SHALL have port pll_resetb, output, 1 bit: drives the PLL RESETB pin, active-low.
REQ-012 SHALL have port rst_out_n, output, NUM_DOMAINS bits: per-domain active-low resets.
REQ-013 SHALL have port ready, output, 1 bit: all domains released.
REQ-014 SHALL have port unlock_count, output, 8 bits: saturating count of loss-of-lock events.
REQ-015 SHALL have port lock_fail, output, 1 bit: sticky flag set on lock timeout.
REQ-016 SHALL have port state, output, 2 bits: current FSM state, for debug.

Function
REQ-017 SHALL synchronize pll_lock through two flops to produce lock_s; all lock decisions SHALL use lock_s.
REQ-018 SHALL implement states PLL_RST=0, WAIT_LOCK=1, RELEASE=2, RUN=3, with all outputs registered.
REQ-019 In PLL_RST: pll_resetb=0, all rst_out_n=0, ready=0; after PLL_RST_CYCLES cycles go to WAIT_LOCK.
REQ-020 In WAIT_LOCK: pll_resetb=1; the stable counter increments while lock_s=1 and clears to 0 when lock_s=0; on reaching LOCK_STABLE_CYCLES go to RELEASE.
REQ-021 In RELEASE: rst_out_n[0] goes high on the first RELEASE cycle; rst_out_n[i] goes high i*STAGGER_CYCLES cycles later; released bits stay high.
REQ-022 One cycle after the last domain is released, the FSM SHALL enter RUN and ready SHALL go to 1.
REQ-023 In RELEASE or RUN, lock_s low for LOSS_FILTER consecutive cycles SHALL, on the next cycle: clear all rst_out_n, clear ready, enter PLL_RST, and increment unlock_count (saturating at 255).
REQ-024 A lock_s low pulse shorter than LOSS_FILTER cycles SHALL be ignored; the filter counter clears when lock_s=1.
REQ-025 sw_reset_req=1 in any state SHALL, on the next cycle: enter PLL_RST, clear all rst_out_n, clear ready, and restart the PLL_RST counter; unlock_count is not incremented.
REQ-026 If sw_reset_req coincides with loss detection, the FSM SHALL enter PLL_RST and unlock_count SHALL increment.
REQ-027 All counters SHALL be sized from their parameters and SHALL NOT wrap.

Reset
REQ-028 While reset=0, the block SHALL asynchronously hold: state=PLL_RST, pll_resetb=0, rst_out_n=0, ready=0, unlock_count=0, lock_fail=0, synchronizer flops=0, all counters=0.
REQ-029 After reset deasserts, the first PLL_RST period SHALL last exactly PLL_RST_CYCLES cycles.

Configuration
REQ-030 With PLL_SEQ_TIMEOUT_EN defined: if WAIT_LOCK lasts LOCK_TIMEOUT cycles without release, the block SHALL set lock_fail (sticky until reset) and return to PLL_RST for a retry.
REQ-031 Without PLL_SEQ_TIMEOUT_EN: WAIT_LOCK SHALL wait indefinitely, lock_fail SHALL be tied to 0, and no timeout counter SHALL exist.

Structure
REQ-032 Package pll_seq_pkg SHALL hold the state typedef and encodings, plus a counter-width function (clog2-based).
REQ-033 The two-flop synchronizer SHALL be a sub-module named pll_lock_sync, 1 bit wide, async active-low reset.

Verification
Bench parameters: NUM_DOMAINS=3, PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=16, STAGGER_CYCLES=8, LOSS_FILTER=3, LOCK_TIMEOUT=100.
REQ-034 Power-up: release reset, pll_lock high from cycle 10 -> pll_resetb high after 4 cycles; rst_out_n bits go 001, 011, 111 at 8-cycle spacing; ready=1 one cycle after 111.
REQ-035 Glitch filter: in RUN, 2-cycle pll_lock low -> no change, unlock_count=0; then a 5-cycle low -> all resets low, unlock_count=1, state=PLL_RST, full re-sequence follows.
REQ-036 Unstable lock: pll_lock toggles every 10 cycles in WAIT_LOCK -> no release; once held high, release occurs 16 cycles after lock_s rises.
REQ-037 sw_reset_req pulse mid-RELEASE (after 011) -> next cycle rst_out_n=000, state=PLL_RST, unlock_count unchanged.
REQ-038 With PLL_SEQ_TIMEOUT_EN, pll_lock held low -> lock_fail=1 at WAIT_LOCK cycle 100, retry visible as pll_resetb low for 4 cycles; without the macro -> lock_fail stays 0 and the FSM stays in WAIT_LOCK.
REQ-039 Async reset asserted in RUN -> all outputs reach their REQ-028 values without a clock edge.
